// File: rtl/rr_grant_sched8_pkg.sv
// Shared types and constants for the 8-way round-robin grant scheduler.
// Holds the FSM state encoding, requester count, index width and default hold limit.
package rr_grant_sched8_pkg;

  localparam int N_REQ        = 8;
  localparam int IDX_W        = 3;
  localparam int MAX_HOLD_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_grant_sched8_dec.sv
// 3-to-8 enabled decoder: one-hot y from index a.
// Ports: a (index), sta (active-high enable), stb/stc (active-low enables), y (one-hot out).
module rr_grant_sched8_dec (
  input  logic [2:0] a,
  input  logic       sta,
  input  logic       stb,
  input  logic       stc,
  output logic [7:0] y
);

  always_comb begin
    y = '0;
    if (sta && !stb && !stc)
      y[a] = 1'b1;
  end

endmodule

// File: rtl/rr_grant_sched8.sv
// Round-robin scheduler for 8 requesters with hold limit and global enable.
// Ports: clk, rst (sync high), en, req[7:0], done -> gnt[7:0], gnt_idx[2:0], gnt_valid, timeout.
module rr_grant_sched8
  import rr_grant_sched8_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int HOLD_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  state_t             state, state_n;
  logic [IDX_W-1:0]   ptr, ptr_n;
  logic [IDX_W-1:0]   idx_n;
  logic [HOLD_W-1:0]  hold_cnt, hold_n;
  logic               valid_n;
  logic               to_n;

  // First set bit of r scanning p, p+1, ... with 3-bit wrap.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [N_REQ-1:0] r,
    input logic [IDX_W-1:0] p
  );
    logic [IDX_W-1:0] k;
    logic             hit;
    rr_pick = p;
    hit     = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      k = p + IDX_W'(i);
      if (!hit && r[k]) begin
        rr_pick = k;
        hit     = 1'b1;
      end
    end
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      hold_cnt  <= '0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      gnt_idx   <= idx_n;
      gnt_valid <= valid_n;
      hold_cnt  <= hold_n;
      timeout   <= to_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    idx_n   = gnt_idx;
    valid_n = 1'b0;
    hold_n  = hold_cnt;
    to_n    = 1'b0;
    unique case (state)
      IDLE: begin
        hold_n = '0;
        if (en && |req) begin
          idx_n   = rr_pick(req, ptr);
          valid_n = 1'b1;
          hold_n  = HOLD_W'(1);
          state_n = GRANT;
        end
      end
      GRANT: begin
        // en=0 and done/req-drop win over the hold limit,
        // so timeout only fires on a clean forced release.
        if (!en || done || !req[gnt_idx]) begin
          state_n = RELEASE;
          ptr_n   = gnt_idx + IDX_W'(1);
        end else if (hold_cnt == HOLD_W'(MAX_HOLD)) begin
          state_n = RELEASE;
          ptr_n   = gnt_idx + IDX_W'(1);
          to_n    = 1'b1;
        end else begin
          valid_n = 1'b1;
          hold_n  = hold_cnt + HOLD_W'(1);
        end
      end
      RELEASE: begin
        hold_n  = '0;
        state_n = IDLE;
      end
      default: begin
        hold_n  = '0;
        state_n = IDLE;
      end
    endcase
  end

  rr_grant_sched8_dec u_dec (
    .a   (gnt_idx),
    .sta (gnt_valid),
    .stb (1'b0),
    .stc (1'b0),
    .y   (gnt)
  );

endmodule

// File: tb/tb_rr_grant_sched8.sv
// Self-checking bench for rr_grant_sched8: vector table plus
// hand-written round-robin, timeout and done/timeout-collision sequences.
module tb_rr_grant_sched8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  rr_grant_sched8 #(.MAX_HOLD(16), .HOLD_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       v;
    logic       to;
    logic       ck;
  } vec_t;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       v;
    logic       to;
    logic       ck;
    string      tag;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[23];

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step(
    input logic r, input logic e, input logic [7:0] q, input logic d,
    input logic [7:0] eg, input logic [2:0] ei, input logic ev,
    input logic eto, input logic ck, input string tag
  );
    exp_t x;
    rst  = r;
    en   = e;
    req  = q;
    done = d;
    sb.push_back('{eg, ei, ev, eto, ck, tag});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({x.tag, " gnt"}, int'(gnt), int'(x.gnt));
    chk({x.tag, " valid"}, int'(gnt_valid), int'(x.v));
    chk({x.tag, " timeout"}, int'(timeout), int'(x.to));
    if (x.ck) chk({x.tag, " idx"}, int'(gnt_idx), int'(x.idx));
    chk({x.tag, " onehot"}, int'($countones(gnt) <= 1), 1);
  endtask

  initial begin
    //           rst en  req   done gnt   idx  v  to ck
    tbl[0]  = '{1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1};
    tbl[1]  = '{0, 1, 8'h01, 0, 8'h01, 0, 1, 0, 1};
    tbl[2]  = '{0, 1, 8'h01, 1, 8'h00, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 8'h00, 0, 8'h00, 0, 0, 0, 0};
    tbl[4]  = '{0, 1, 8'h03, 0, 8'h02, 1, 1, 0, 1};
    tbl[5]  = '{0, 1, 8'h03, 1, 8'h00, 0, 0, 0, 0};
    tbl[6]  = '{0, 1, 8'h00, 0, 8'h00, 0, 0, 0, 0};
    tbl[7]  = '{0, 1, 8'h08, 0, 8'h08, 3, 1, 0, 1};
    tbl[8]  = '{0, 0, 8'h08, 1, 8'h00, 3, 0, 0, 1};
    tbl[9]  = '{0, 0, 8'h08, 0, 8'h00, 3, 0, 0, 1};
    tbl[10] = '{0, 0, 8'hFF, 0, 8'h00, 3, 0, 0, 1};
    tbl[11] = '{0, 0, 8'hFF, 0, 8'h00, 3, 0, 0, 1};
    tbl[12] = '{0, 1, 8'h40, 0, 8'h40, 6, 1, 0, 1};
    tbl[13] = '{1, 1, 8'h40, 0, 8'h00, 0, 0, 0, 1};
    tbl[14] = '{0, 1, 8'h41, 0, 8'h01, 0, 1, 0, 1};
    tbl[15] = '{0, 1, 8'h41, 1, 8'h00, 0, 0, 0, 0};
    tbl[16] = '{0, 1, 8'h00, 0, 8'h00, 0, 0, 0, 0};
    tbl[17] = '{0, 1, 8'h81, 0, 8'h80, 7, 1, 0, 1};
    tbl[18] = '{0, 1, 8'h01, 0, 8'h00, 0, 0, 0, 0};
    tbl[19] = '{0, 1, 8'h81, 0, 8'h00, 0, 0, 0, 0};
    tbl[20] = '{0, 1, 8'h81, 0, 8'h01, 0, 1, 0, 1};
    tbl[21] = '{0, 1, 8'h81, 1, 8'h00, 0, 0, 0, 0};
    tbl[22] = '{0, 1, 8'h00, 0, 8'h00, 0, 0, 0, 0};

    for (int i = 0; i < 23; i++)
      step(tbl[i].rst, tbl[i].en, tbl[i].req, tbl[i].done,
           tbl[i].gnt, tbl[i].idx, tbl[i].v, tbl[i].to,
           tbl[i].ck, $sformatf("vec%0d", i));

    // Round robin over all requesters, ptr back at 0 after reset.
    step(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1, "rr_rst");
    for (int k = 0; k < 9; k++) begin
      logic [7:0] oh;
      oh = 8'h01 << (k % 8);
      step(0, 1, 8'hFF, 0, oh, 3'(k % 8), 1, 0, 1, $sformatf("rr%0d_g", k));
      step(0, 1, 8'hFF, 0, oh, 3'(k % 8), 1, 0, 1, $sformatf("rr%0d_h", k));
      step(0, 1, 8'hFF, 1, 8'h00, 0, 0, 0, 0, $sformatf("rr%0d_rel", k));
      step(0, 1, 8'hFF, 0, 8'h00, 0, 0, 0, 0, $sformatf("rr%0d_gap", k));
    end

    // Forced release after exactly 16 held cycles.
    step(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1, "to_rst");
    for (int c = 1; c <= 16; c++)
      step(0, 1, 8'h10, 0, 8'h10, 4, 1, 0, 1, $sformatf("to_hold%0d", c));
    step(0, 1, 8'h10, 0, 8'h00, 0, 0, 1, 0, "to_pulse");
    step(0, 1, 8'h10, 0, 8'h00, 0, 0, 0, 0, "to_gap");
    step(0, 1, 8'h10, 0, 8'h10, 4, 1, 0, 1, "to_regrant");

    // done coinciding with the hold limit suppresses timeout.
    for (int c = 2; c <= 16; c++)
      step(0, 1, 8'h10, 0, 8'h10, 4, 1, 0, 1, $sformatf("dt_hold%0d", c));
    step(0, 1, 8'h10, 1, 8'h00, 0, 0, 0, 0, "dt_done");
    step(0, 1, 8'h10, 0, 8'h00, 0, 0, 0, 0, "dt_gap");
    step(0, 1, 8'h10, 0, 8'h10, 4, 1, 0, 1, "dt_regrant");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/rr_grant_sched8.md
Name: rr_grant_sched8

Overview:
- 8-requester round-robin scheduler for a shared resource. Produces a registered 3-bit grant index and a one-hot 8-bit grant vector.
- The one-hot vector is the index decoded through the team's 3-to-8 enabled decoder. The enable is driven by the scheduler's grant-valid state.
- Sits between requesting units and the shared bus/resource. Enforces fairness, a hold limit and a global enable.

Parameters:
- N_REQ, 8, number of requesters. Fixed at 8; the index is 3 bits.
- MAX_HOLD, 16, maximum cycles one grant may be held before forced release. Legal range 1..255.
- HOLD_W, 8, width of the hold counter. Must satisfy MAX_HOLD <= 2^HOLD_W - 1.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  global scheduler enable
- req  in  8  request vector; bit i = requester i
- done  in  1  release pulse from the current grantee
- gnt  out  8  one-hot grant; all-zero when no grant
- gnt_idx  out  3  index of the current grantee; valid only when gnt_valid=1
- gnt_valid  out  1  a grant is active
- timeout  out  1  one-cycle pulse when a grant is force-released at MAX_HOLD

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is synchronous and active-high: sampled on the rising clk edge while rst=1.
- Reset values:
  - state=IDLE, gnt_valid=0, gnt_idx=0, gnt=8'h00, timeout=0.
  - ptr=0 (round-robin start), hold_cnt=0.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If en=1 and req!=0: select the first set bit of req, scanning ptr, ptr+1, ..., ptr+7 (mod 8).
  - Load gnt_idx with that bit, set gnt_valid=1, hold_cnt=1, go to GRANT.
  - The grant appears the cycle after the request is sampled (latency 1).
  - Otherwise stay in IDLE with outputs at their reset values (gnt_idx holds its last value).
- GRANT, in priority order:
  1. en=0 → go to RELEASE, drop gnt_valid at the same edge.
  2. done=1, or req[gnt_idx]=0 → go to RELEASE, gnt_valid=0.
  3. hold_cnt==MAX_HOLD → go to RELEASE, gnt_valid=0, timeout=1 for exactly one cycle.
  4. Otherwise stay in GRANT and increment hold_cnt.
- Ptr update: on every exit from GRANT, ptr <= gnt_idx+1, 3-bit wrap (7→0).
- RELEASE:
  - One dead cycle: gnt=0, gnt_valid=0. Unconditionally go to IDLE.
  - Two grants are therefore never adjacent; the minimum gap is 2 cycles (RELEASE plus IDLE arbitration).
- Simultaneous events:
  - done and timeout in the same cycle → treated as done; timeout stays 0.
  - en=0 and done together → treated as the en=0 path; timeout stays 0.
- Output invariants:
  - gnt is purely decoded from the registered gnt_idx with enable=gnt_valid. No other combinational path from req to gnt.
  - gnt has at most one bit set in every cycle.
  - gnt==0 whenever gnt_valid=0.
- Requests:
  - Changes to req while in GRANT do not affect the grantee, except via the grantee's own bit dropping.
  - New requests are considered only in IDLE.
- Reset mid-grant: the next edge returns to the reset values, with gnt=0 immediately after that edge. ptr returns to 0.
- hold_cnt saturates. It never wraps because exit occurs at MAX_HOLD.

Decomposition:
- Shared package contains:
  - state enum: IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2
  - constants N_REQ=8 and IDX_W=3
  - the default MAX_HOLD
- Sub-module: instantiate the existing 3-to-8 decoder to produce gnt:
  - a=gnt_idx
  - sta=gnt_valid
  - stb=0, stc=0
- The rotate-and-priority-encode selection stays in this module as a combinational function.

Test Plan:
- Reset then req=8'h01, en=1 → after 1 cycle gnt=8'h01, gnt_idx=0, gnt_valid=1. Pulse done → next cycle gnt=0; ptr=1.
- req=8'hFF held, each grantee pulses done after 2 cycles → grant order 0,1,2,...,7,0. Each grant is separated by a 2-cycle gap of gnt=0.
- req=8'h10 held, done never asserted, MAX_HOLD=16 → gnt=8'h10 for exactly 16 cycles. timeout=1 for one cycle, then after the gap re-grant to index 4 (only requester).
- Grant to index 3 active, drive en=0 → next cycle gnt=0, gnt_valid=0, timeout=0. With en held 0 and req!=0, no new grant occurs.
- Grant to index 6, assert rst for 1 cycle → next cycle gnt=0 and gnt_idx=0. With req=8'h41 after reset, the first grant goes to index 0 (ptr=0).
- Grant to index 7 with req=8'h81, requester 7 drops req → release, ptr wraps to 0. The next grant goes to index 0, gnt=8'h01.
